// File: rtl/tree_loader.sv
// tree_loader: accepts packed tree-node words over a valid/ready stream and
// replays each node as four field writes (weight, parent, reward, action) onto
// the evaluator sideband. A one-cycle config beat announces the node count
// before the first node, and a done pulse follows the last action write.
module tree_loader #(
  parameter int NODE_SIZE        = 32,
  parameter int W_ADDR           = 10,
  parameter int MAX_DATA_WIDTH   = 12,
  parameter int MAX_CONFIG_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [W_ADDR-1:0]           num_nodes,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NODE_SIZE-1:0]        in_node,
  output logic                        mem_weight,
  output logic                        mem_par,
  output logic                        mem_rew,
  output logic                        mem_act,
  output logic [W_ADDR-1:0]           mem_addr,
  output logic [MAX_DATA_WIDTH-1:0]   mem_data,
  output logic                        conf_nodes,
  output logic [MAX_CONFIG_WIDTH-1:0] conf_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  // Node word layout, packed from the MSB down:
  //   parent (W_ADDR) | action (3) | reward (MAX_DATA_WIDTH, signed) | weight (rest)
  localparam int ACT_W   = 3;
  localparam int PAR_LSB = NODE_SIZE - W_ADDR;
  localparam int ACT_LSB = PAR_LSB - ACT_W;
  localparam int REW_LSB = ACT_LSB - MAX_DATA_WIDTH;
  localparam int WT_W    = REW_LSB;

  // The root has no parent; the evaluator expects an all-ones address there.
  localparam logic [W_ADDR-1:0] ROOT_PARENT = {W_ADDR{1'b1}};
  localparam logic [W_ADDR-1:0] MIN_NODES   = W_ADDR'(2);

  typedef enum logic [2:0] {
    IDLE,
    CONF,
    WAIT,
    WR_WT,
    WR_PAR,
    WR_REW,
    WR_ACT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [W_ADDR-1:0]      count_q, count_d;
  logic [W_ADDR-1:0]      addr_q,  addr_d;
  logic [NODE_SIZE-1:0]   node_q,  node_d;
  logic                   err_q,   err_d;

  // Field views of the captured node word.
  logic [W_ADDR-1:0]         fld_parent;
  logic [ACT_W-1:0]          fld_action;
  logic [MAX_DATA_WIDTH-1:0] fld_reward;
  logic [WT_W-1:0]           fld_weight;
  logic                      last_node;

  assign fld_parent = node_q[NODE_SIZE-1:PAR_LSB];
  assign fld_action = node_q[PAR_LSB-1:ACT_LSB];
  assign fld_reward = node_q[ACT_LSB-1:REW_LSB];
  assign fld_weight = node_q[WT_W-1:0];

  // True while the node being written is the final one of the tree.
  assign last_node = (addr_q == (count_q - W_ADDR'(1)));

  // The write address is simply the node counter; it only moves between nodes.
  assign mem_addr = addr_q;
  assign err      = err_q;

  // State and datapath registers; active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      node_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      node_q  <= node_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and Moore-style sideband outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    node_d     = node_q;
    err_d      = 1'b0;
    in_ready   = 1'b0;
    mem_weight = 1'b0;
    mem_par    = 1'b0;
    mem_rew    = 1'b0;
    mem_act    = 1'b0;
    mem_data   = '0;
    conf_nodes = 1'b0;
    conf_data  = '0;
    done       = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_nodes >= MIN_NODES) begin
            count_d = num_nodes;
            addr_d  = '0;
            state_d = CONF;
          end else begin
            // A tree needs a root and at least one child.
            err_d = 1'b1;
          end
        end
      end

      CONF: begin
        conf_nodes = 1'b1;
        conf_data  = MAX_CONFIG_WIDTH'(count_q);
        state_d    = WAIT;
      end

      WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          node_d  = in_node;
          state_d = WR_WT;
        end
      end

      WR_WT: begin
        mem_weight = 1'b1;
        mem_data   = MAX_DATA_WIDTH'(fld_weight);
        state_d    = WR_PAR;
      end

      WR_PAR: begin
        mem_par  = 1'b1;
        mem_data = (addr_q == '0) ? MAX_DATA_WIDTH'(ROOT_PARENT)
                                  : MAX_DATA_WIDTH'(fld_parent);
        state_d  = WR_REW;
      end

      WR_REW: begin
        // Raw two's-complement pattern; the consumer reinterprets the sign.
        mem_rew  = 1'b1;
        mem_data = fld_reward;
        state_d  = WR_ACT;
      end

      WR_ACT: begin
        mem_act  = 1'b1;
        mem_data = MAX_DATA_WIDTH'(fld_action);
        // Accepting the next word here keeps the stream at one node per
        // four cycles instead of paying an extra WAIT cycle per node.
        in_ready = !last_node;
        if (last_node) begin
          state_d = DONE;
        end else begin
          addr_d = addr_q + W_ADDR'(1);
          if (in_valid) begin
            node_d  = in_node;
            state_d = WR_WT;
          end else begin
            state_d = WAIT;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tree_loader.sv
// Scoreboard bench for tree_loader: every driven start/node pushes the events
// it must cause; a negedge monitor pops and compares each observed event.
module tb_tree_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  num_nodes = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_node = '0;
  logic        in_ready;
  logic        mem_weight, mem_par, mem_rew, mem_act;
  logic [9:0]  mem_addr;
  logic [11:0] mem_data;
  logic        conf_nodes;
  logic [9:0]  conf_data;
  logic        busy, done, err;

  tree_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_nodes  (num_nodes),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_node    (in_node),
    .mem_weight (mem_weight),
    .mem_par    (mem_par),
    .mem_rew    (mem_rew),
    .mem_act    (mem_act),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .conf_nodes (conf_nodes),
    .conf_data  (conf_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hot;
  logic [31:0] sb[$];
  int          act_cycles[$];

  localparam int EV_CONF = 1, EV_WT = 2, EV_PAR = 3, EV_REW = 4,
                 EV_ACT = 5, EV_DONE = 6, EV_ERR = 7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] pack_ev(input int kind, input logic [9:0] a, input logic [11:0] d);
    return {6'b0, 4'(kind), a, d};
  endfunction

  task automatic consume(input logic [31:0] obs);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      check_eq("sb_unexpected", obs, 32'h0);
    end else begin
      exp = sb.pop_front();
      $display("ev kind=%0d addr=0x%0h data=0x%0h", obs[25:22], obs[21:12], obs[11:0]);
      check_eq("sb_event", obs, exp);
    end
  endtask

  // Monitor: one-hot sideband check and scoreboard consumption each cycle.
  always @(negedge clk) begin
    hot = int'(mem_weight) + int'(mem_par) + int'(mem_rew) + int'(mem_act) + int'(conf_nodes);
    check_eq("onehot", 32'(hot <= 1), 32'h1);
    if (err)        consume(pack_ev(EV_ERR, 10'h0, 12'h0));
    if (conf_nodes) consume(pack_ev(EV_CONF, 10'h0, {2'b0, conf_data}));
    if (mem_weight) consume(pack_ev(EV_WT, mem_addr, mem_data));
    if (mem_par)    consume(pack_ev(EV_PAR, mem_addr, mem_data));
    if (mem_rew)    consume(pack_ev(EV_REW, mem_addr, mem_data));
    if (mem_act) begin
      consume(pack_ev(EV_ACT, mem_addr, mem_data));
      act_cycles.push_back(cyc);
    end
    if (done)       consume(pack_ev(EV_DONE, 10'h0, 12'h0));
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic do_start(input logic [9:0] n);
    start = 1'b1;
    num_nodes = n;
    if (n >= 10'd2) sb.push_back(pack_ev(EV_CONF, 10'h0, {2'b0, n}));
    else            sb.push_back(pack_ev(EV_ERR, 10'h0, 12'h0));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [9:0] a, input int n_fields);
    logic [11:0] exp_par;
    bit ok;
    exp_par = (a == 10'd0) ? 12'h3FF : {2'b0, w[31:22]};
    if (n_fields > 0) sb.push_back(pack_ev(EV_WT,  a, {5'b0, w[6:0]}));
    if (n_fields > 1) sb.push_back(pack_ev(EV_PAR, a, exp_par));
    if (n_fields > 2) sb.push_back(pack_ev(EV_REW, a, w[18:7]));
    if (n_fields > 3) sb.push_back(pack_ev(EV_ACT, a, {9'b0, w[21:19]}));
    in_valid = 1'b1;
    in_node  = w;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      check_eq("hs_timeout", 32'h0, 32'h1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !busy) break;
    end
    check_eq("load_end", 32'(sb.size() == 0 && !busy), 32'h1);
  endtask

  initial begin
    // Reset held for two cycles.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'h0);
    check_eq("rst_strobes",  32'({mem_weight, mem_par, mem_rew, mem_act}), 32'h0);
    check_eq("rst_addr",     32'(mem_addr), 32'h0);
    check_eq("rst_data",     32'(mem_data), 32'h0);
    check_eq("rst_conf",     32'({conf_nodes, conf_data}), 32'h0);
    check_eq("rst_flags",    32'({busy, done, err}), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Rejected starts.
    do_start(10'd1);
    check_eq("bad_err",  32'(err), 32'h1);
    check_eq("bad_busy", 32'(busy), 32'h0);
    check_eq("bad_conf", 32'(conf_nodes), 32'h0);
    @(posedge clk); #1;
    check_eq("bad_err_pulse", 32'(err), 32'h0);
    do_start(10'd0);
    @(posedge clk); #1;

    // Load of 3 nodes: root with parent field 5, the reference node, one random.
    do_start(10'd3);
    check_eq("conf_nodes", 32'(conf_nodes), 32'h1);
    check_eq("conf_data",  32'(conf_data), 32'd3);
    send_word(32'h0140_0000 | ($urandom & 32'h003F_FFFF), 10'd0, 4);
    send_word(32'h0010_3232, 10'd1, 4);
    send_word($urandom, 10'd2, 4);
    sb.push_back(pack_ev(EV_DONE, 10'h0, 12'h0));
    wait_idle();

    // Stall in WAIT with a start that must be ignored.
    do_start(10'd3);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_busy",    32'(busy), 32'h1);
      check_eq("stall_ready",   32'(in_ready), 32'h1);
      check_eq("stall_strobes", 32'({mem_weight, mem_par, mem_rew, mem_act}), 32'h0);
      start = 1'b1;
      num_nodes = 10'd1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_eq("busy_start_err", 32'(err), 32'h0);
    for (int n = 0; n < 3; n++) send_word($urandom, 10'(n), 4);
    sb.push_back(pack_ev(EV_DONE, 10'h0, 12'h0));
    wait_idle();

    // Back-to-back words: one node per four cycles.
    do_start(10'd4);
    act_cycles.delete();
    for (int n = 0; n < 4; n++) send_word($urandom, 10'(n), 4);
    sb.push_back(pack_ev(EV_DONE, 10'h0, 12'h0));
    wait_idle();
    check_eq("b2b_count", 32'(act_cycles.size()), 32'd4);
    for (int i = 1; i < act_cycles.size(); i++)
      check_eq("b2b_spacing", 32'(act_cycles[i] - act_cycles[i-1]), 32'd4);

    // Reset during node 1's parent write.
    do_start(10'd3);
    send_word($urandom, 10'd0, 4);
    send_word($urandom, 10'd1, 2);
    @(posedge clk); #1;
    check_eq("mid_par", 32'(mem_par), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_strobes", 32'({mem_weight, mem_par, mem_rew, mem_act}), 32'h0);
    check_eq("mid_busy",    32'(busy), 32'h0);
    check_eq("mid_addr",    32'(mem_addr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    check_eq("mid_sb_empty", 32'(sb.size()), 32'h0);
    @(posedge clk); #1;
    do_start(10'd2);
    send_word($urandom, 10'd0, 4);
    send_word($urandom, 10'd1, 4);
    sb.push_back(pack_ev(EV_DONE, 10'h0, 12'h0));
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tree_loader.md
TREE_LOADER -- requirements
Module: tree_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NODE_SIZE  32  packed node word width
  W_ADDR  10  node address width
  MAX_DATA_WIDTH  12  sideband data width
  MAX_CONFIG_WIDTH  10  config data width
REQ-002 Node word packing SHALL be parent[31:22], action[21:19], reward[18:7] (signed), weight[6:0].
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on its rising edge
  rst  in  1  synchronous, active-low reset (0 = reset)
  start  in  1  begin a tree load; sampled only in IDLE
  num_nodes  in  10  node count; latched on an accepted start
  in_valid  in  1  in_node holds a valid node word
  in_ready  out  1  loader accepts in_node this cycle
  in_node  in  32  packed node word, addresses ascending from 0
  mem_weight / mem_par / mem_rew / mem_act  out  1 each  field-write strobes to the evaluator sideband
  mem_addr  out  10  node address of the current field write
  mem_data  out  12  field value, zero-extended
  conf_nodes  out  1  conf_data carries the node count
  conf_data  out  10  node count
  busy  out  1  load in progress
  done  out  1  one-cycle pulse when the load completes
  err  out  1  one-cycle pulse when a start is rejected

Function
REQ-004 The FSM SHALL have the states IDLE, CONF, WAIT, WR_WT, WR_PAR, WR_REW, WR_ACT and DONE.
REQ-005 In IDLE, start=1 with num_nodes>=2 SHALL latch num_nodes, clear the address counter to 0 and go to CONF.
REQ-006 In IDLE, start=1 with num_nodes<2 SHALL pulse err for 1 cycle and stay in IDLE.
REQ-007 CONF SHALL last 1 cycle, driving conf_nodes=1 and conf_data=latched count, then go to WAIT.
REQ-008 in_ready SHALL be 1 in WAIT, and in WR_ACT when the current address is not count-1; it SHALL be 0 otherwise.
REQ-009 A handshake (in_valid and in_ready) SHALL register in_node; the next state SHALL be WR_WT.
REQ-010 A handshake in WR_ACT SHALL also increment mem_addr after the action write, giving a 4-cycle-per-node sustained rate.
REQ-011 WR_WT, WR_PAR, WR_REW and WR_ACT SHALL each last 1 cycle, asserting only their own strobe with mem_data equal to weight, parent, reward or action respectively.
REQ-012 At most one of mem_weight, mem_par, mem_rew, mem_act and conf_nodes SHALL be high in any cycle.
REQ-013 Reward SHALL pass as its raw 12-bit two's-complement pattern; weight, parent and action SHALL be zero-extended to 12 bits.
REQ-014 The parent write for address 0 SHALL drive 10'h3FF regardless of the word's parent field.
REQ-015 Leaving WR_ACT with no handshake SHALL go to WAIT (address+1) when address<count-1, and to DONE when address==count-1.
REQ-016 DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 start while busy SHALL be ignored, with no err pulse.
REQ-019 in_valid low in WAIT SHALL stall indefinitely with no strobes asserted.
REQ-020 mem_addr SHALL hold its value for all four field writes of a node and SHALL never exceed count-1.

Reset
REQ-021 When rst=0 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 (in_ready, strobes, mem_addr, mem_data, conf_data, busy, done, err).
REQ-022 Reset mid-load SHALL abandon the load with no further writes; field writes already issued SHALL not be retracted.

Verification
REQ-023 Reset: hold rst=0 for 2 cycles -> all outputs 0, state IDLE.
REQ-024 Load: start, num_nodes=3 -> conf_nodes=1 with conf_data=3 for 1 cycle; node 1 word 0x00103232 -> at mem_addr 1, writes 0x032, 0x000, 0x064, 0x002 on 4 consecutive cycles; done after node 2's action write.
REQ-025 Root parent: node-0 word with parent=5 -> mem_par write at addr 0 with mem_data 0x3FF.
REQ-026 Back-to-back valid words -> one node retired every 4 cycles; in_valid low for 3 cycles in WAIT -> no strobes, busy=1.
REQ-027 Bad start: start with num_nodes=1 -> err pulse, no conf_nodes, busy stays 0.
REQ-028 Reset mid-load: rst=0 during node 1's WR_PAR -> strobes 0 on the next cycle; a new start then issues conf_nodes followed by writes beginning at addr 0.
